iterative_mul_div_unit: RTL and testbench

Multi-cycle unsigned multiply/divide execute unit that sits directly downstream of the dual-read-port register file.
- Consumes the two read-port operands and a destination address.
- Produces a single-cycle write-back (enable, address, data) that drives the register file write port.
- Lets the single-cycle ALU path stay small while MUL/DIV instructions stall the pipe via a busy flag.

---
 rtl/iterative_mul_div_unit_pkg.sv | 25 ++
 rtl/iterative_mul_div_unit_mul_div_step.sv | 50 +++++
 rtl/iterative_mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_iterative_mul_div_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide execute unit.
//   - op_e    : 2-bit operation encoding carried from decode (iOperation)
//   - state_e : control FSM states (IDLE -> RUN -> WRITE -> IDLE)
//   - op_is_div : true for either divide flavour
package iterative_mul_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MUL_LO  = 2'b00,
        OP_MUL_HI  = 2'b01,
        OP_DIV_QUO = 2'b10,
        OP_DIV_REM = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    // The upper opcode bit distinguishes divide from multiply.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/iterative_mul_div_unit_mul_div_step.sv
// mul_div_step: one combinational iteration of either unsigned shift-add
// multiply or unsigned restoring divide.
//   is_div_i : 1 = divide step, 0 = multiply step
//   p_i/p_o  : 2*DATA_WIDTH product register (multiply only)
//   r_i/r_o  : DATA_WIDTH+1 partial remainder (divide only)
//   q_i/q_o  : DATA_WIDTH quotient / dividend shift register (divide only)
//   b_i      : multiplier / divisor
// Registers not used by the selected mode pass through unchanged.
module mul_div_step #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      is_div_i,
    input  logic [2*DATA_WIDTH-1:0]   p_i,
    input  logic [DATA_WIDTH:0]       r_i,
    input  logic [DATA_WIDTH-1:0]     q_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic [2*DATA_WIDTH-1:0]   p_o,
    output logic [DATA_WIDTH:0]       r_o,
    output logic [DATA_WIDTH-1:0]     q_o
);

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH+1:0] r_shift;
    logic [DATA_WIDTH+1:0] r_sub;
    logic                  fits;

    always_comb begin
        // Multiply: conditional add into the upper half keeps its carry,
        // which becomes the new MSB after the right shift.
        mul_sum = {1'b0, p_i[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (p_i[0] ? {1'b0, b_i} : '0);

        // Divide: shift {R, Q} left by one, then trial-subtract B.
        // Held one bit wider than R so the compare never overflows.
        r_shift = {r_i, q_i[DATA_WIDTH-1]};
        r_sub   = r_shift - (DATA_WIDTH+2)'(b_i);
        fits    = (r_shift >= (DATA_WIDTH+2)'(b_i));

        p_o = p_i;
        r_o = r_i;
        q_o = q_i;
        if (is_div_i) begin
            r_o = fits ? (DATA_WIDTH+1)'(r_sub) : (DATA_WIDTH+1)'(r_shift);
            q_o = {q_i[DATA_WIDTH-2:0], fits};
        end else begin
            p_o = {mul_sum, p_i[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iterative_mul_div_unit.sv
// iterative_mul_div_unit: multi-cycle unsigned MUL/DIV execute unit feeding
// the register file write port.
//   Clock, Reset      : clock, synchronous active-high reset
//   iStart            : launch request, honoured only in IDLE
//   iOperation        : MUL_LO / MUL_HI / DIV_QUO / DIV_REM
//   iOperandA/B       : multiplicand-dividend / multiplier-divisor
//   iDestination      : write-back register address
//   oBusy             : high while an operation is in flight (stall)
//   oWriteEnable      : one-cycle write-back strobe
//   oWriteAddress/Data: write-back address / result (zero when not writing)
//   oDivByZero        : flags a divide whose divisor was zero, with the strobe
// All outputs are registered images of the FSM state, so each appears one
// edge after the state that produces it.
module iterative_mul_div_unit
    import iterative_mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [1:0]            iOperation,
    input  logic [DATA_WIDTH-1:0] iOperandA,
    input  logic [DATA_WIDTH-1:0] iOperandB,
    input  logic [ADDR_WIDTH-1:0] iDestination,
    output logic                  oBusy,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic                  oDivByZero
);

    localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [2*DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH:0]     r_q, r_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [ADDR_WIDTH-1:0]   dest_q, dest_d;
    logic                    dbz_q, dbz_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    busy_q, we_q, dbz_out_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic [2*DATA_WIDTH-1:0] p_step;
    logic [DATA_WIDTH:0]     r_step;
    logic [DATA_WIDTH-1:0]   q_step;
    logic [DATA_WIDTH-1:0]   result;

    mul_div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .is_div_i (op_is_div(op_q)),
        .p_i      (p_q),
        .r_i      (r_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .p_o      (p_step),
        .r_o      (r_step),
        .q_o      (q_step)
    );

    // Next-state and datapath load/iterate logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        p_d     = p_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        dest_d  = dest_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    op_d    = op_e'(iOperation);
                    b_d     = iOperandB;
                    dest_d  = iDestination;
                    p_d     = {{DATA_WIDTH{1'b0}}, iOperandA};
                    r_d     = '0;
                    q_d     = iOperandA;
                    cnt_d   = '0;
                    dbz_d   = iOperation[1] && (iOperandB == '0);
                    // A zero divisor skips the iterations entirely.
                    state_d = dbz_d ? ST_WRITE : ST_RUN;
                end
            end
            ST_RUN: begin
                p_d   = p_step;
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result select; with a zero divisor Q still holds the dividend.
    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL_LO:  result = p_q[DATA_WIDTH-1:0];
            OP_MUL_HI:  result = p_q[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV_QUO: result = dbz_q ? '1 : q_q;
            OP_DIV_REM: result = dbz_q ? q_q : DATA_WIDTH'(r_q);
            default:    result = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL_LO;
            p_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            dest_q  <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            p_q     <= p_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered Moore outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            busy_q    <= (state_q != ST_IDLE);
            we_q      <= (state_q == ST_WRITE);
            addr_q    <= (state_q == ST_WRITE) ? dest_q : '0;
            data_q    <= (state_q == ST_WRITE) ? result : '0;
            dbz_out_q <= (state_q == ST_WRITE) && dbz_q;
        end
    end

    assign oBusy         = busy_q;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oWriteData    = data_q;
    assign oDivByZero    = dbz_out_q;

endmodule

// File: tb/tb_iterative_mul_div_unit.sv
module tb_iterative_mul_div_unit;

    localparam int W  = 16;
    localparam int AW = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iStart = 1'b0;
    logic [1:0]    iOperation = '0;
    logic [W-1:0]  iOperandA = '0;
    logic [W-1:0]  iOperandB = '0;
    logic [AW-1:0] iDestination = '0;
    logic          oBusy;
    logic          oWriteEnable;
    logic [AW-1:0] oWriteAddress;
    logic [W-1:0]  oWriteData;
    logic          oDivByZero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 Clock = ~Clock;

    iterative_mul_div_unit #(
        .DATA_WIDTH(W),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iOperation    (iOperation),
        .iOperandA     (iOperandA),
        .iOperandB     (iOperandB),
        .iDestination  (iDestination),
        .oBusy         (oBusy),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oDivByZero    (oDivByZero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One in-flight operation: accepted when idle, result computed with plain
    // arithmetic, written back W+1 edges later (1 edge for a zero divisor).
    bit            m_active = 1'b0;
    int            m_start = 0;
    int            m_write = 0;
    logic [W-1:0]  m_data = '0;
    logic [AW-1:0] m_addr = '0;
    bit            m_dbz = 1'b0;

    always @(posedge Clock) begin
        longint unsigned a, b, prod;
        cyc++;
        if (Reset) begin
            m_active = 1'b0;
        end else if (iStart && !(m_active && cyc <= m_write)) begin
            a = iOperandA;
            b = iOperandB;
            prod = a * b;
            m_active = 1'b1;
            m_start  = cyc;
            m_addr   = iDestination;
            m_dbz    = iOperation[1] && (b == 0);
            m_write  = cyc + (m_dbz ? 1 : W + 1);
            case (iOperation)
                2'd0: m_data = W'(prod);
                2'd1: m_data = W'(prod >> W);
                2'd2: m_data = (b == 0) ? {W{1'b1}} : W'(a / b);
                default: m_data = (b == 0) ? W'(a) : W'(a % b);
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clock) begin
        bit e_busy, e_we;
        if (cyc >= 1) begin
            e_busy = m_active && (cyc > m_start) && (cyc <= m_write);
            e_we   = m_active && (cyc == m_write);
            check("busy", 64'(oBusy), 64'(e_busy));
            check("we", 64'(oWriteEnable), 64'(e_we));
            check("addr", 64'(oWriteAddress), e_we ? 64'(m_addr) : 64'd0);
            check("data", 64'(oWriteData), e_we ? 64'(m_data) : 64'd0);
            check("dbz", 64'(oDivByZero), (e_we && m_dbz) ? 64'd1 : 64'd0);
        end
    end

    // Write-back log and busy cycle counter for the literal checks.
    logic [W-1:0]  wr_data[$];
    logic [AW-1:0] wr_addr[$];
    logic          wr_dbz[$];
    int            wr_cyc[$];
    int            busy_total = 0;

    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            wr_data.push_back(oWriteData);
            wr_addr.push_back(oWriteAddress);
            wr_dbz.push_back(oDivByZero);
            wr_cyc.push_back(cyc);
            $display("write: edge %0d addr %0h data %0h dbz %0b", cyc, oWriteAddress, oWriteData, oDivByZero);
        end
        if (oBusy === 1'b1) busy_total++;
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, output int s);
        @(negedge Clock);
        iStart = 1'b1; iOperation = op; iOperandA = a; iOperandB = b; iDestination = d;
        @(negedge Clock);
        iStart = 1'b0;
        s = cyc;
    endtask

    task automatic pulse_at(input int target, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [AW-1:0] d);
        while (cyc < target - 1) @(negedge Clock);
        iStart = 1'b1; iOperation = op; iOperandA = a; iOperandB = b; iDestination = d;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [AW-1:0] d,
                          input logic [W-1:0] exp_data, input int exp_lat, input bit exp_dbz);
        int n0, b0, s, waited;
        n0 = wr_data.size();
        b0 = busy_total;
        pulse(op, a, b, d, s);
        waited = 0;
        while (wr_data.size() == n0 && waited < 60) begin
            @(negedge Clock);
            waited++;
        end
        check({name, "_written"}, 64'(wr_data.size()), 64'(n0 + 1));
        if (wr_data.size() > n0) begin
            check({name, "_data"}, 64'(wr_data[n0]), 64'(exp_data));
            check({name, "_addr"}, 64'(wr_addr[n0]), 64'(d));
            check({name, "_latency"}, 64'(wr_cyc[n0] - s), 64'(exp_lat));
            check({name, "_divzero"}, 64'(wr_dbz[n0]), 64'(exp_dbz));
        end
        @(negedge Clock);
        check({name, "_busy_cycles"}, 64'(busy_total - b0), 64'(exp_lat));
        $display("op %s: a=%0h b=%0h done", name, a, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n0;
        repeat (3) @(negedge Clock);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_we", 64'(oWriteEnable), 64'd0);
        check("rst_addr", 64'(oWriteAddress), 64'd0);
        check("rst_data", 64'(oWriteData), 64'd0);
        check("rst_dbz", 64'(oDivByZero), 64'd0);
        Reset = 1'b0;
        @(negedge Clock);

        run_op("mul_lo_300x200", 2'd0, 16'd300, 16'd200, 8'd5, 16'hEA60, 17, 1'b0);
        run_op("mul_hi_300x200", 2'd1, 16'd300, 16'd200, 8'd5, 16'h0000, 17, 1'b0);
        run_op("mul_hi_ffff",    2'd1, 16'hFFFF, 16'hFFFF, 8'd9, 16'hFFFE, 17, 1'b0);
        run_op("mul_lo_ffff",    2'd0, 16'hFFFF, 16'hFFFF, 8'd9, 16'h0001, 17, 1'b0);
        run_op("div_quo_100_7",  2'd2, 16'd100, 16'd7, 8'd3, 16'd14, 17, 1'b0);
        run_op("div_rem_100_7",  2'd3, 16'd100, 16'd7, 8'd3, 16'd2, 17, 1'b0);
        run_op("div_quo_by0",    2'd2, 16'd1234, 16'd0, 8'd7, 16'hFFFF, 1, 1'b1);
        run_op("div_rem_by0",    2'd3, 16'd1234, 16'd0, 8'd7, 16'd1234, 1, 1'b1);
        run_op("mul_hi_by0",     2'd1, 16'd1234, 16'd0, 8'd8, 16'd0, 17, 1'b0);
        run_op("div_quo_big",    2'd2, 16'hFFFF, 16'd3, 8'hA5, 16'h5555, 17, 1'b0);

        // Starts while busy are dropped; the one right after WRITE is taken.
        n0 = wr_data.size();
        pulse(2'd0, 16'd3, 16'd4, 8'h11, s);
        pulse_at(s + 5,  2'd0, 16'd9, 16'd9, 8'h22);
        pulse_at(s + 17, 2'd0, 16'd9, 16'd9, 8'h22);
        pulse_at(s + 18, 2'd0, 16'd9, 16'd9, 8'h33);
        while (cyc < s + 40) @(negedge Clock);
        check("b2b_count", 64'(wr_data.size() - n0), 64'd2);
        check("b2b_first_data", 64'(wr_data[n0]), 64'd12);
        check("b2b_first_lat", 64'(wr_cyc[n0] - s), 64'd17);
        check("b2b_second_data", 64'(wr_data[n0 + 1]), 64'd81);
        check("b2b_second_lat", 64'(wr_cyc[n0 + 1] - s), 64'd35);
        check("b2b_second_addr", 64'(wr_addr[n0 + 1]), 64'h33);
        $display("op back_to_back: done");

        // Reset mid-run aborts without a write-back.
        n0 = wr_data.size();
        pulse(2'd2, 16'd100, 16'd7, 8'd1, s);
        while (cyc < s + 7) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_busy", 64'(oBusy), 64'd0);
        check("abort_we", 64'(oWriteEnable), 64'd0);
        check("abort_data", 64'(oWriteData), 64'd0);
        while (cyc < s + 30) @(negedge Clock);
        check("abort_no_write", 64'(wr_data.size()), 64'(n0));
        $display("op reset_abort: done");

        run_op("after_reset_div", 2'd2, 16'd100, 16'd7, 8'd4, 16'd14, 17, 1'b0);

        repeat (3) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
